fb_write_arbiter: RTL and testbench

- Owns the write port of the double-buffered frame memory.
- Runs the back-buffer clear sweep when the system controller raises mem_str_clr, then reports mem_clr_finish.
- After the clear, grants the line drawer single-pixel writes through a req/ack handshake.
- Sits between the system controller / line drawer and the two frame memory banks. The display read side is not touched.

---
 rtl/fb_write_arbiter_if.sv | 38 +++
 rtl/fb_write_arbiter.sv | 137 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Write-side bundle between the system controller / line drawer and fb_write_arbiter.
// FB_DRAW_CNT_EN adds the draw_cnt status signal.
interface fb_write_arbiter_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 8
);
   logic              mem_str_clr;
   logic              swap;
   logic              drw_req;
   logic [ADDR_W-1:0] drw_addr;
   logic [DATA_W-1:0] drw_data;
   logic              drw_ack;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_bank;
   logic              mem_clr_finish;
   logic              busy;
`ifdef FB_DRAW_CNT_EN
   logic [ADDR_W:0]   draw_cnt;
`endif

   modport master (
      output mem_str_clr, swap, drw_req, drw_addr, drw_data,
      input  drw_ack, mem_we, mem_addr, mem_wdata, mem_bank, mem_clr_finish, busy
`ifdef FB_DRAW_CNT_EN
      , input draw_cnt
`endif
   );

   modport slave (
      input  mem_str_clr, swap, drw_req, drw_addr, drw_data,
      output drw_ack, mem_we, mem_addr, mem_wdata, mem_bank, mem_clr_finish, busy
`ifdef FB_DRAW_CNT_EN
      , output draw_cnt
`endif
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame memory write-port owner: back-buffer clear sweep, then single-pixel drawer writes.
// Optional FB_DRAW_CNT_EN adds a saturating count of in-range drawer writes (draw_cnt).
module fb_write_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned FRAME_PIXELS = 19200,
   parameter int unsigned CLR_VALUE    = 0
) (
   input  logic              clk,
   input  logic              reset,
   fb_write_arbiter_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [DATA_W-1:0] CLR_WORD  = DATA_W'(CLR_VALUE);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE, DRAW} state_t;

   state_t            state_q, state_d;
   logic              clr_q;
   logic              rise;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic              bank_q, bank_d;
   logic              fin_q, fin_d;
   logic              busy_q, busy_d;
`ifdef FB_DRAW_CNT_EN
   logic [ADDR_W:0]   dcnt_q, dcnt_d;
`endif

   assign rise = bus.mem_str_clr & ~clr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         clr_q   <= 1'b0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         bank_q  <= 1'b0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef FB_DRAW_CNT_EN
         dcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         clr_q   <= bus.mem_str_clr;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         bank_q  <= bank_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
`ifdef FB_DRAW_CNT_EN
         dcnt_q  <= dcnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      bank_d  = bank_q;
      fin_d   = fin_q;
      busy_d  = 1'b0;
`ifdef FB_DRAW_CNT_EN
      dcnt_d  = dcnt_q;
`endif
      if (rise) begin
         // Clear start outranks everything, including a drawer request accepted this cycle.
         state_d = CLEAR;
         cnt_d   = '0;
         bank_d  = bus.swap;
         fin_d   = 1'b0;
         busy_d  = 1'b1;
`ifdef FB_DRAW_CNT_EN
         dcnt_d  = '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            CLEAR: begin
               // The registered write of LAST_ADDR marks the end; the counter itself never wraps.
               if (we_q && addr_q == LAST_ADDR) begin
                  fin_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  busy_d  = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = cnt_q;
                  wdata_d = CLR_WORD;
                  if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (!bus.mem_str_clr) state_d = DRAW;
            end
            DRAW: begin
               if (bus.drw_req && !ack_q) begin
                  ack_d = 1'b1;
                  if (bus.drw_addr <= LAST_ADDR) begin
                     we_d    = 1'b1;
                     addr_d  = bus.drw_addr;
                     wdata_d = bus.drw_data;
`ifdef FB_DRAW_CNT_EN
                     if (dcnt_q != '1) dcnt_d = dcnt_q + 1'b1;
`endif
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.drw_ack        = ack_q;
   assign bus.mem_we         = we_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.mem_bank       = bank_q;
   assign bus.mem_clr_finish = fin_q;
   assign bus.busy           = busy_q;
`ifdef FB_DRAW_CNT_EN
   assign bus.draw_cnt       = dcnt_q;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter with a 16-pixel frame.
// An elapsed-cycle model is compared every cycle; literal checks pin key scenarios.
module tb_fb_write_arbiter;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 8;
   localparam int FP = 16;
   localparam logic [DATA_W-1:0] CLR = 8'h00;
   localparam int DCNT_MAX = (1 << (ADDR_W + 1)) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;

   fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fb_write_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .FRAME_PIXELS(FP),
      .CLR_VALUE(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Model: clear progress derived from cycles elapsed since the rising edge.
   int cyc = 0, edge_cyc = 0, e_dcnt = 0;
   bit prev_clr = 0, clearing = 0, finished = 0, draw_ok = 0, m_bank = 0;
   bit e_we = 0, e_ack = 0, e_busy = 0, e_fin = 0;
   logic [ADDR_W-1:0] e_addr = '0;
   logic [DATA_W-1:0] e_wdata = '0;

   initial forever begin
      bit rise, ack_prev;
      int since;
      @(posedge clk or posedge reset);
      if (reset) begin
         cyc = 0; prev_clr = 0; clearing = 0; finished = 0; draw_ok = 0; m_bank = 0;
         e_we = 0; e_ack = 0; e_busy = 0; e_fin = 0; e_addr = '0; e_wdata = '0; e_dcnt = 0;
      end else begin
         cyc++;
         rise = bus.mem_str_clr && !prev_clr;
         prev_clr = bus.mem_str_clr;
         ack_prev = e_ack;
         e_we = 0; e_ack = 0; e_busy = 0;
         if (rise) begin
            edge_cyc = cyc; m_bank = bus.swap; clearing = 1; finished = 0; draw_ok = 0;
            e_fin = 0; e_busy = 1; e_dcnt = 0;
         end else if (clearing) begin
            since = cyc - edge_cyc;
            if (since <= FP) begin
               e_busy = 1; e_we = 1; e_addr = ADDR_W'(since - 1); e_wdata = CLR;
            end else begin
               e_fin = 1; clearing = 0; finished = 1;
            end
         end else if (draw_ok) begin
            if (bus.drw_req && !ack_prev) begin
               e_ack = 1;
               if (int'(bus.drw_addr) < FP) begin
                  e_we = 1; e_addr = bus.drw_addr; e_wdata = bus.drw_data;
                  if (e_dcnt < DCNT_MAX) e_dcnt++;
               end
            end
         end else if (finished && !bus.mem_str_clr) begin
            draw_ok = 1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      cmp("m_we", bus.mem_we, e_we);
      cmp("m_ack", bus.drw_ack, e_ack);
      cmp("m_busy", bus.busy, e_busy);
      cmp("m_fin", bus.mem_clr_finish, e_fin);
      cmp("m_bank", bus.mem_bank, m_bank);
      if (e_we) begin
         cmp("m_addr", bus.mem_addr, e_addr);
         cmp("m_wdata", bus.mem_wdata, e_wdata);
      end
`ifdef FB_DRAW_CNT_EN
      cmp("m_dcnt", bus.draw_cnt, e_dcnt);
`endif
   end

   task automatic draw_pixel(input int a, input int d, input string nm);
      bit seen;
      seen = 0;
      bus.drw_req = 1; bus.drw_addr = ADDR_W'(a); bus.drw_data = DATA_W'(d);
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (bus.drw_ack) seen = 1;
      end
      cmp({nm, "_ack"}, seen, 1);
      cmp({nm, "_we"}, bus.mem_we, 1);
      cmp({nm, "_addr"}, bus.mem_addr, a);
      cmp({nm, "_data"}, bus.mem_wdata, d);
      bus.drw_req = 0;
      tick();
   endtask

   initial begin
      int wr, fin_edge, acks, first_addr;
      bit hit;
      bus.mem_str_clr = 0; bus.swap = 0; bus.drw_req = 0; bus.drw_addr = '0; bus.drw_data = '0;
      repeat (2) tick();
      cmp("rst_we", bus.mem_we, 0);
      cmp("rst_ack", bus.drw_ack, 0);
      cmp("rst_busy", bus.busy, 0);
      cmp("rst_fin", bus.mem_clr_finish, 0);
      cmp("rst_bank", bus.mem_bank, 0);
      reset = 0;

      // Drawer request in IDLE is never acked.
      bus.drw_req = 1; bus.drw_addr = 2; bus.drw_data = 8'h44;
      repeat (3) tick();
      cmp("idle_ack", bus.drw_ack, 0);
      bus.drw_req = 0;

      // Clear sweep into bank 1; swap and mem_str_clr changes mid-sweep are ignored.
      bus.swap = 1; bus.mem_str_clr = 1;
      wr = 0; fin_edge = -1;
      for (int i = 1; i <= 40 && fin_edge < 0; i++) begin
         tick();
         if (i == 3) bus.swap = 0;
         if (i == 5) bus.mem_str_clr = 0;
         if (bus.mem_we) begin
            cmp("clr_addr", bus.mem_addr, wr);
            cmp("clr_data", bus.mem_wdata, 0);
            cmp("clr_busy", bus.busy, 1);
            wr++;
         end
         if (bus.mem_clr_finish) fin_edge = i - 1;
      end
      cmp("clr_writes", wr, 16);
      cmp("clr_latency", fin_edge, 17);
      cmp("clr_bank", bus.mem_bank, 1);
      cmp("clr_busy_end", bus.busy, 0);

      // DONE -> DRAW, then one pixel write; holding req through the ack gives no second write.
      tick();
      bus.drw_req = 1; bus.drw_addr = 5; bus.drw_data = 8'hA7;
      tick();
      cmp("px5_ack", bus.drw_ack, 1);
      cmp("px5_we", bus.mem_we, 1);
      cmp("px5_addr", bus.mem_addr, 5);
      cmp("px5_data", bus.mem_wdata, 8'hA7);
      tick();
      cmp("px5_hold_ack", bus.drw_ack, 0);
      cmp("px5_hold_we", bus.mem_we, 0);
      bus.drw_req = 0;
      tick();

      // Out-of-range address: acked, dropped.
      bus.drw_req = 1; bus.drw_addr = 16; bus.drw_data = 8'h33;
      tick();
      cmp("oor_ack", bus.drw_ack, 1);
      cmp("oor_we", bus.mem_we, 0);
`ifdef FB_DRAW_CNT_EN
      cmp("oor_dcnt", bus.draw_cnt, 1);
`endif
      bus.drw_req = 0;
      tick();

      draw_pixel(0, 8'h11, "px0");
      draw_pixel(15, 8'h22, "px15");
`ifdef FB_DRAW_CNT_EN
      cmp("dcnt3", bus.draw_cnt, 3);
`endif

      // Clear edge coincides with a request: clear wins, request waits for DRAW.
      bus.drw_req = 1; bus.drw_addr = 3; bus.drw_data = 8'h5C;
      bus.mem_str_clr = 1;
      tick();
      cmp("coll_ack", bus.drw_ack, 0);
      cmp("coll_busy", bus.busy, 1);
`ifdef FB_DRAW_CNT_EN
      cmp("coll_dcnt", bus.draw_cnt, 0);
`endif
      acks = 0; first_addr = -1; hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (bus.drw_ack) acks++;
         if (bus.mem_we && first_addr < 0) first_addr = int'(bus.mem_addr);
         if (bus.mem_clr_finish) hit = 1;
      end
      cmp("coll_fin", hit, 1);
      cmp("coll_first_addr", first_addr, 0);
      cmp("coll_clr_acks", acks, 0);
      bus.mem_str_clr = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.drw_ack) begin
            acks++;
            cmp("held_we", bus.mem_we, 1);
            cmp("held_addr", bus.mem_addr, 3);
            cmp("held_data", bus.mem_wdata, 8'h5C);
            bus.drw_req = 0;
         end
      end
      cmp("held_acks", acks, 1);
      cmp("held_req_dropped", bus.drw_req, 0);
`ifdef FB_DRAW_CNT_EN
      cmp("held_dcnt", bus.draw_cnt, 1);
`endif

      // Reset while the sweep writes address 7.
      bus.mem_str_clr = 1;
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         tick();
         if (bus.mem_we && bus.mem_addr == 7) hit = 1;
      end
      cmp("rst7_reached", hit, 1);
      #2;
      reset = 1; bus.mem_str_clr = 0;
      #1;
      cmp("rst7_we", bus.mem_we, 0);
      cmp("rst7_addr", bus.mem_addr, 0);
      cmp("rst7_wdata", bus.mem_wdata, 0);
      cmp("rst7_busy", bus.busy, 0);
      cmp("rst7_bank", bus.mem_bank, 0);
      cmp("rst7_fin", bus.mem_clr_finish, 0);
      cmp("rst7_ack", bus.drw_ack, 0);
      repeat (2) tick();
      reset = 0;
      repeat (4) tick();
      cmp("post_rst_we", bus.mem_we, 0);
      cmp("post_rst_busy", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
